muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle RV64M multiply/divide unit with its sequencing FSM. Sits beside the single-cycle ALU in the execute stage.
- Execute hands it an M-extension op and both operands, then stalls until the result returns.
- Owns operand latching, iteration counting, sign fix-up, divide special cases, W-variant sign extension, and the result handshake toward execute.

Parameters:
- XLEN, 64, datapath width; only 64 is supported. W ops use the low 32 bits.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  execute presents an M op
- in_ready  out  1  unit can accept a new op this cycle
- op  in  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW; 13-15 reserved
- srca  in  XLEN  rs1 value, already forwarded
- srcb  in  XLEN  rs2 value, already forwarded
- flush  in  1  kill any in-flight op (redirect or exception)
- out_valid  out  1  result valid
- out_ready  in  1  execute consumes the result
- result  out  XLEN  final result; W ops are sign-extended from bit 31
- busy  out  1  state != IDLE; execute uses it to stall

Behaviour:
- Reset (async, any state): state=IDLE, out_valid=0, result=0, counter=0, all operand/accumulator registers cleared.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) && !flush.
- Accept occurs when in_valid && in_ready. op, operands, sign flags and N are latched on the accept edge.
- N = 64 for 64-bit ops, 32 for W ops.
- Reserved op on accept: go directly to DONE with result=0.
- IDLE -> DONE (special case, 1 cycle). Special cases are decided at accept:
  - Divisor==0: DIV/DIVU/DIVW/DIVUW return all-ones; REM* return the dividend (sign-extended for W).
  - Signed overflow, i.e. dividend = most-negative and divisor = -1 at op width: DIV/DIVW return the dividend; REM/REMW return 0.
- IDLE -> RUN otherwise. Counter is loaded with N.
- RUN, one step per cycle:
  - Multiply: shift-add over the magnitude of srcb into a 2*XLEN product.
  - Divide: restoring radix-2 on magnitudes.
  - Counter decrements each cycle. At counter==1 the step completes and the next state is DONE.
- Sign fix-up is applied on entry to DONE; result is registered there:
  - MULH/MULHSU: negate the product if the operand signs differ (MULHSU treats srcb as unsigned).
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the dividend's sign.
  - MUL returns product[63:0]; MULH* return product[127:64]; W ops return sext(x[31:0]).
- Latency: out_valid rises at accept+1+N for normal ops, i.e. 65 cycles, or 33 for W ops. Special and reserved cases rise at accept+1.
- DONE: out_valid=1 and result is held stable until out_ready. On out_valid && out_ready, next state is IDLE and out_valid falls next cycle.
  - No accept in the handshake cycle, since in_ready=0 there.
  - Back-to-back ops therefore have a 1-cycle IDLE gap.
- flush: from any state, next state is IDLE, out_valid=0 next cycle, and the result is discarded.
  - flush and in_valid in the same cycle: flush wins and nothing is accepted.
  - flush and out_ready in DONE in the same cycle: treated as a flush, though the result was already visible that cycle.
- Operand inputs are ignored after accept; changing srca/srcb during RUN has no effect.
- out_valid is never asserted in IDLE or RUN.

Test Plan:
- Reset mid-RUN: accept DIV, assert reset at cycle 10 -> state IDLE, out_valid=0, in_ready=1 immediately after reset deasserts.
- MUL 0xFFFF_FFFF_FFFF_FFFD(-3) x 7 -> out_valid at accept+65, result 0xFFFF_FFFF_FFFF_FFEB. MULHU 0xFFFF_FFFF_FFFF_FFFF x 2 -> result 1.
- DIV -7/2 -> result 0xFFFF_FFFF_FFFF_FFFD. REM -7/2 -> result 0xFFFF_FFFF_FFFF_FFFF. DIVUW 0x1_0000_0008 / 3 -> result 2 at accept+33.
- DIV x/0 with x=5 -> all-ones at accept+1. REM 5/0 -> 5. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000. REMW 0x8000_0000/-1 -> 0, all at accept+1.
- out_ready held low for 10 cycles after out_valid -> result stable, busy=1, in_ready=0. Then out_ready=1 -> IDLE next cycle; a new in_valid is accepted one cycle later.
- flush at RUN cycle 20 with in_valid=1 the same cycle -> no accept, IDLE next cycle, no out_valid ever. A following MULW 0x7FFF_FFFF x 2 -> 0xFFFF_FFFF_FFFF_FFFE.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential RV64M multiply/divide unit. One shift-add or restoring-divide step per
// cycle; divide special cases and reserved ops short-circuit straight to DONE.
module muldiv_seq #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned DW = 2 * XLEN;
  localparam int unsigned HW = XLEN / 2;
  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [DW-1:0]   x_q, x_n, acc_q, acc_n, acc_s, x_s, prod;
  logic [XLEN-1:0] y_q, y_n, y_s, result_n;
  logic            w_q, w_n, mul_q, mul_n, rem_q, rem_n, hi_q, hi_n, neg_q, neg_n;
  logic            out_valid_n;

  logic            dec_w, dec_mul, dec_quo, dec_rem, dec_hi, dec_sa, dec_sb, dec_rsvd;
  logic [XLEN-1:0] opa, opb, mag_a, mag_b, special_res;
  logic            neg_a, neg_b, dzero, ovf, special;
  logic [XLEN:0]   div_sh;
  logic            div_ge;
  logic [XLEN-1:0] div_rm, quo, rmd, fix_raw, fix_res;

  function automatic logic [XLEN-1:0] sext_w(input logic [HW-1:0] v);
    return {{(XLEN-HW){v[HW-1]}}, v};
  endfunction

  assign in_ready = (state == IDLE) && !flush;
  assign busy     = (state != IDLE);

  // Op decode: class, width and operand signedness
  always_comb begin
    dec_w = 1'b0; dec_mul = 1'b0; dec_quo = 1'b0; dec_rem = 1'b0;
    dec_hi = 1'b0; dec_sa = 1'b0; dec_sb = 1'b0; dec_rsvd = 1'b0;
    case (op)
      4'd0:  dec_mul = 1'b1;
      4'd1:  begin dec_mul = 1'b1; dec_hi = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      4'd2:  begin dec_mul = 1'b1; dec_hi = 1'b1; dec_sa = 1'b1; end
      4'd3:  begin dec_mul = 1'b1; dec_hi = 1'b1; end
      4'd4:  begin dec_quo = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      4'd5:  dec_quo = 1'b1;
      4'd6:  begin dec_rem = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      4'd7:  dec_rem = 1'b1;
      4'd8:  begin dec_mul = 1'b1; dec_w = 1'b1; end
      4'd9:  begin dec_quo = 1'b1; dec_w = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      4'd10: begin dec_quo = 1'b1; dec_w = 1'b1; end
      4'd11: begin dec_rem = 1'b1; dec_w = 1'b1; dec_sa = 1'b1; dec_sb = 1'b1; end
      4'd12: begin dec_rem = 1'b1; dec_w = 1'b1; end
      default: dec_rsvd = 1'b1;
    endcase
  end

  // Operand width extension, magnitudes and accept-time special cases
  always_comb begin
    opa = dec_w ? (dec_sa ? sext_w(srca[HW-1:0]) : {{(XLEN-HW){1'b0}}, srca[HW-1:0]}) : srca;
    opb = dec_w ? (dec_sb ? sext_w(srcb[HW-1:0]) : {{(XLEN-HW){1'b0}}, srcb[HW-1:0]}) : srcb;
    neg_a = dec_sa & opa[XLEN-1];
    neg_b = dec_sb & opb[XLEN-1];
    mag_a = neg_a ? -opa : opa;
    mag_b = neg_b ? -opb : opb;
    dzero = (dec_quo | dec_rem) && (opb == '0);
    ovf   = (dec_quo | dec_rem) && dec_sa && (opa == (dec_w ? MIN_W : MIN_D)) && (opb == '1);
    special = dec_rsvd | dzero | ovf;
    special_res = '0;
    if (dzero)
      special_res = dec_rem ? (dec_w ? sext_w(srca[HW-1:0]) : srca) : '1;
    else if (ovf)
      special_res = dec_rem ? '0 : opa;
  end

  // One iteration: shift-add for multiply, restoring step for divide
  always_comb begin
    div_sh = {acc_q[XLEN-1:0], y_q[XLEN-1]};
    div_ge = div_sh >= {1'b0, x_q[XLEN-1:0]};
    div_rm = div_ge ? XLEN'(div_sh - {1'b0, x_q[XLEN-1:0]}) : div_sh[XLEN-1:0];
    if (mul_q) begin
      acc_s = acc_q + (y_q[0] ? x_q : '0);
      x_s   = x_q << 1;
      y_s   = y_q >> 1;
    end else begin
      acc_s = {{XLEN{1'b0}}, div_rm};
      x_s   = x_q;
      y_s   = {y_q[XLEN-2:0], div_ge};
    end
  end

  // Sign fix-up and result selection from the final step's values
  always_comb begin
    prod = neg_q ? -acc_s : acc_s;
    quo  = neg_q ? -y_s : y_s;
    rmd  = neg_q ? -acc_s[XLEN-1:0] : acc_s[XLEN-1:0];
    if (mul_q) fix_raw = hi_q ? prod[DW-1:XLEN] : prod[XLEN-1:0];
    else       fix_raw = rem_q ? rmd : quo;
    fix_res = w_q ? sext_w(fix_raw[HW-1:0]) : fix_raw;
  end

  always_comb begin
    state_n = state; cnt_n = cnt_q; x_n = x_q; y_n = y_q; acc_n = acc_q;
    w_n = w_q; mul_n = mul_q; rem_n = rem_q; hi_n = hi_q; neg_n = neg_q;
    result_n = result; out_valid_n = out_valid;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_n   = dec_w;
          mul_n = dec_mul;
          rem_n = dec_rem;
          hi_n  = dec_hi;
          neg_n = dec_rem ? neg_a : (neg_a ^ neg_b);
          cnt_n = dec_w ? CW'(HW) : CW'(XLEN);
          acc_n = '0;
          if (dec_mul) begin
            x_n = {{XLEN{1'b0}}, mag_a};
            y_n = mag_b;
          end else begin
            // W dividends sit in the top half so every step consumes y_q's MSB
            x_n = {{XLEN{1'b0}}, mag_b};
            y_n = dec_w ? {mag_a[HW-1:0], {HW{1'b0}}} : mag_a;
          end
          if (special) begin
            state_n = DONE;
            result_n = special_res;
            out_valid_n = 1'b1;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        x_n = x_s; y_n = y_s; acc_n = acc_s;
        cnt_n = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_n = DONE;
          result_n = fix_res;
          out_valid_n = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
          out_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      out_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE; cnt_q <= '0; x_q <= '0; y_q <= '0; acc_q <= '0;
      w_q <= 1'b0; mul_q <= 1'b0; rem_q <= 1'b0; hi_q <= 1'b0; neg_q <= 1'b0;
      result <= '0; out_valid <= 1'b0;
    end else begin
      state <= state_n; cnt_q <= cnt_n; x_q <= x_n; y_q <= y_n; acc_q <= acc_n;
      w_q <= w_n; mul_q <= mul_n; rem_q <= rem_n; hi_q <= hi_n; neg_q <= neg_n;
      result <= result_n; out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: arithmetic reference model plus a per-cycle output monitor.
module tb_muldiv_seq;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk, reset, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [3:0]  op;
  logic [63:0] srca, srcb, result;

  int          n_pass = 0, n_chk = 0, cyc = 0;
  logic        pend = 1'b0;
  logic [63:0] exp_res = '0;
  int          exp_cyc = 0;

  muldiv_seq #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .srca(srca), .srcb(srcb), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // RISC-V M semantics computed directly with wide arithmetic
  function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic signed [63:0] as, bs, qs;
    logic signed [31:0] aw, bw, qw;
    logic [31:0] au, bu;
    logic [63:0] r;
    as = a; bs = b; aw = a[31:0]; bw = b[31:0]; au = a[31:0]; bu = b[31:0];
    r = '0;
    case (o)
      4'd0: r = a * b;
      4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
      4'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      4'd4: if (b == 64'd0) r = ONES;
            else if (a == MIN64 && b == ONES) r = a;
            else begin qs = as / bs; r = qs; end
      4'd5: r = (b == 64'd0) ? ONES : a / b;
      4'd6: if (b == 64'd0) r = a;
            else if (a == MIN64 && b == ONES) r = '0;
            else begin qs = as % bs; r = qs; end
      4'd7: r = (b == 64'd0) ? a : a % b;
      4'd8: r = sx(au * bu);
      4'd9: if (bu == 32'd0) r = ONES;
            else if (au == 32'h8000_0000 && bu == 32'hFFFF_FFFF) r = sx(au);
            else begin qw = aw / bw; r = sx(qw); end
      4'd10: r = (bu == 32'd0) ? ONES : sx(au / bu);
      4'd11: if (bu == 32'd0) r = sx(au);
             else if (au == 32'h8000_0000 && bu == 32'hFFFF_FFFF) r = '0;
             else begin qw = aw % bw; r = sx(qw); end
      4'd12: r = (bu == 32'd0) ? sx(au) : sx(au % bu);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Cycles from accept to first visible out_valid
  function automatic int lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    if (o > 4'd12) return 1;
    if (o >= 4'd4 && o <= 4'd7) begin
      if (b == 64'd0) return 1;
      if ((o == 4'd4 || o == 4'd6) && a == MIN64 && b == ONES) return 1;
      return 65;
    end
    if (o >= 4'd9) begin
      if (b[31:0] == 32'd0) return 1;
      if ((o == 4'd9 || o == 4'd11) && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (o == 4'd8) return 33;
    return 65;
  endfunction

  // Output monitor: out_valid only at/after the modelled cycle, with the modelled result
  always @(negedge clk) begin
    if (!reset) begin
      if (pend && cyc >= exp_cyc) begin
        check("out_valid", {63'd0, out_valid}, 64'd1);
        check("result", result, exp_res);
        check("busy_done", {63'd0, busy}, 64'd1);
        if (out_valid && out_ready) pend = 1'b0;
      end else begin
        check("no_valid", {63'd0, out_valid}, 64'd0);
        if (pend) check("busy_run", {63'd0, busy}, 64'd1);
      end
      if (flush) pend = 1'b0;
    end
  end

  task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, output int acc_cyc);
    int w;
    w = 0;
    op = o; srca = a; srcb = b; in_valid = 1'b1;
    do begin @(negedge clk); w++; end while (!in_ready && w < 200);
    if (!in_ready) begin
      check("accept_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      acc_cyc = -1;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 4'd15; srca = ~a; srcb = a ^ b ^ 64'h5A5A_A5A5_0F0F_F0F0;
      exp_res = model(o, a, b);
      exp_cyc = cyc + lat(o, a, b) - 1;
      pend = 1'b1;
      acc_cyc = cyc;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (pend && n < 200) begin @(posedge clk); #1; n++; end
    check("done_timeout", {63'd0, pend}, 64'd0);
    pend = 1'b0;
  endtask

  task automatic run(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    int c;
    issue(o, a, b, c);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, hs, n;
    reset = 1'b1; in_valid = 1'b0; op = '0; srca = '0; srcb = '0;
    flush = 1'b0; out_ready = 1'b1;

    // Pin the reference model with hand-computed values
    check("pin_mul", model(4'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7), 64'hFFFF_FFFF_FFFF_FFEB);
    check("pin_mulhu", model(4'd3, ONES, 64'd2), 64'd1);
    check("pin_div", model(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("pin_rem", model(4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), ONES);
    check("pin_divuw", model(4'd10, 64'h1_0000_0008, 64'd3), 64'd2);
    check("pin_div0", model(4'd4, 64'd5, 64'd0), ONES);
    check("pin_rem0", model(4'd6, 64'd5, 64'd0), 64'd5);
    check("pin_divovf", model(4'd4, MIN64, ONES), MIN64);
    check("pin_remwovf", model(4'd11, 64'h8000_0000, ONES), 64'd0);
    check("pin_mulw", model(4'd8, 64'h7FFF_FFFF, 64'd2), 64'hFFFF_FFFF_FFFF_FFFE);
    check("pin_lat64", 64'(lat(4'd0, 64'd1, 64'd1)), 64'd65);
    check("pin_latw", 64'(lat(4'd10, 64'h1_0000_0008, 64'd3)), 64'd33);
    check("pin_latsp", 64'(lat(4'd4, 64'd5, 64'd0)), 64'd1);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Reset during RUN
    issue(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, c);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1; pend = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_result", result, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed vectors (test-plan and boundary cases)
    run(4'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7);
    run(4'd3, ONES, 64'd2);
    run(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    run(4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    run(4'd10, 64'h1_0000_0008, 64'd3);
    run(4'd4, 64'd5, 64'd0);
    run(4'd6, 64'd5, 64'd0);
    run(4'd4, MIN64, ONES);
    run(4'd11, 64'h8000_0000, ONES);
    run(4'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3);
    run(4'd1, MIN64, MIN64);
    run(4'd2, ONES, 64'd2);
    run(4'd5, 64'd100, 64'd7);
    run(4'd7, 64'd100, 64'd7);
    run(4'd5, 64'd9, 64'd0);
    run(4'd9, 64'h0000_0000_FFFF_FFEC, 64'd6);
    run(4'd11, 64'h0000_0000_FFFF_FFEC, 64'd6);
    run(4'd12, 64'h1234_5678_FFFF_FFEC, 64'd6);
    run(4'd12, 64'h0000_0000_8000_0001, 64'h1_0000_0000);
    run(4'd9, 64'h8000_0000, 64'hFFFF_FFFF);
    run(4'd8, 64'hFFFF_FFFF_8000_0001, 64'h3);
    run(4'd14, 64'd11, 64'd13);
    run(4'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 16; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = (i % 5 == 4) ? 64'd0 : {$urandom, $urandom} >> (i * 3);
      run(4'($urandom_range(0, 15)), ra, rb);
    end

    // Result held while out_ready is low; next op accepted one cycle after the handshake
    out_ready = 1'b0;
    issue(4'd0, 64'd123456789, 64'd987654321, c);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    check("stall_valid_seen", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_busy", {63'd0, busy}, 64'd1);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    hs = cyc;
    issue(4'd7, 64'd1000, 64'd33, c);
    check("accept_after_hs", 64'(c), 64'(hs + 2));
    wait_done();

    // flush and out_ready together in DONE
    out_ready = 1'b0;
    issue(4'd4, 64'd5, 64'd0, c);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flushdone_valid", {63'd0, out_valid}, 64'd0);
    check("flushdone_busy", {63'd0, busy}, 64'd0);

    // flush mid-RUN with a competing in_valid
    issue(4'd4, 64'd100, 64'd7, c);
    repeat (19) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = 4'd0; srca = 64'd3; srcb = 64'd4;
    #1;
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    repeat (80) @(posedge clk);
    #1;
    run(4'd8, 64'h7FFF_FFFF, 64'd2);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
